// File: rtl/rom_arbiter_if.sv
// Bus between two burst requesters, the ROM arbiter and a synchronous ROM.
// The arbiter sits on the slave modport; the requesters and the ROM model sit on master.
interface rom_arbiter_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 4
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [LW-1:0] len0;
  logic [LW-1:0] len1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic          rready0;
  logic          rready1;
  logic          rlast;
  logic [DW-1:0] rdata;
  logic [DW-1:0] ROM_out_i;
  logic          ROM_read_o;
  logic          ROM_en_o;
  logic [AW-1:0] ROM_addr_o;

  modport master (
    output req0, req1, addr0, addr1, len0, len1, rready0, rready1, ROM_out_i,
    input  gnt0, gnt1, rvalid0, rvalid1, rlast, rdata, ROM_read_o, ROM_en_o, ROM_addr_o
  );

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, rready0, rready1, ROM_out_i,
    output gnt0, gnt1, rvalid0, rvalid1, rlast, rdata, ROM_read_o, ROM_en_o, ROM_addr_o
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin burst arbiter in front of a one-cycle-latency ROM.
// A grant issues the first ROM address in the same cycle so beat 0 is valid one cycle later.
module rom_arbiter #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 4
) (
  input logic         clk,
  input logic         rst,
  rom_arbiter_if.slave bus
);

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  state_e        r_state;
  logic          r_owner;
  logic          r_ptr;
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;

  logic          w_any_req;
  logic          w_winner;
  logic          w_grant;
  logic          w_in_burst;
  logic          w_rready;
  logic          w_hs;
  logic          w_last;
  logic [AW-1:0] w_win_addr;
  logic [LW-1:0] w_win_len;
  logic [AW-1:0] w_beat_addr;

  always_comb begin
    w_any_req = bus.req0 | bus.req1;
    // The pointer only matters when both requesters compete.
    if (bus.req0 && bus.req1) begin
      w_winner = r_ptr;
    end else begin
      w_winner = bus.req1;
    end
    w_win_addr  = w_winner ? bus.addr1 : bus.addr0;
    w_win_len   = w_winner ? bus.len1 : bus.len0;
    w_in_burst  = (r_state == StBurst);
    // Gated by rst so no grant is visible while reset is held.
    w_grant     = rst & (r_state == StIdle) & w_any_req;
    w_rready    = r_owner ? bus.rready1 : bus.rready0;
    w_hs        = w_in_burst & w_rready;
    w_last      = w_in_burst & (r_cnt == r_len);
    // Advance the ROM address only on a handshake so rdata holds during a stall.
    w_beat_addr = r_base + AW'(r_cnt) + AW'(w_hs);
  end

  always_comb begin
    bus.gnt0    = w_grant & ~w_winner;
    bus.gnt1    = w_grant & w_winner;
    bus.rvalid0 = w_in_burst & ~r_owner;
    bus.rvalid1 = w_in_burst & r_owner;
    bus.rlast   = w_last;
    bus.rdata   = bus.ROM_out_i;
    bus.ROM_read_o = w_grant | w_in_burst;
    bus.ROM_en_o   = w_grant | w_in_burst;
    if (w_in_burst) begin
      bus.ROM_addr_o = w_beat_addr;
    end else if (w_grant) begin
      bus.ROM_addr_o = w_win_addr;
    end else begin
      bus.ROM_addr_o = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_base  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_state <= StBurst;
            r_owner <= w_winner;
            r_ptr   <= ~w_winner;
            r_base  <= w_win_addr;
            r_len   <= w_win_len;
            r_cnt   <= '0;
          end
        end
        StBurst: begin
          if (w_hs) begin
            if (w_last) begin
              r_state <= StIdle;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a ROM model answers one cycle after each enabled read, and a queue
// of expected beats is filled at each grant and drained as the owner handshakes.
module tb_rom_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rom_arbiter_if #(.AW(AW), .DW(DW), .LW(LW)) rif ();

  rom_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rif.slave)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {8'hD0, a, ~a};
  endfunction

  logic [DW-1:0] rom_out = '0;
  always @(posedge clk) begin
    if (rif.ROM_en_o && rif.ROM_read_o) rom_out <= rom_word(rif.ROM_addr_o);
  end
  assign rif.ROM_out_i = rom_out;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          port;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic port, input logic [AW-1:0] base, input int len);
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      b.addr = base + AW'(i);
      b.data = rom_word(b.addr);
      b.last = (i == len);
      b.port = port;
      exp_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    rif.req0 = 1'b1; rif.req1 = 1'b0;
    rif.addr0 = 12'h123; rif.addr1 = '0; rif.len0 = '0; rif.len1 = '0;
    rif.rready0 = 1'b1; rif.rready1 = 1'b1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
         rif.ROM_en_o} !== 7'b0 || rif.ROM_addr_o !== '0 || rif.rdata !== rom_out) begin
      errors++;
      $display("FAIL reset_hold: gnt/rv/last/rd/en=%b addr=%h rdata=%h, want 0 0 rdata=%h",
               {rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
                rif.ROM_en_o}, rif.ROM_addr_o, rif.rdata, rom_out);
    end
    rif.req0 = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
         rif.ROM_en_o} !== 7'b0 || rif.ROM_addr_o !== '0 || rif.rdata !== rom_out) begin
      errors++;
      $display("FAIL reset_release: gnt/rv/last/rd/en=%b addr=%h rdata=%h, want 0 0 rdata=%h",
               {rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
                rif.ROM_en_o}, rif.ROM_addr_o, rif.rdata, rom_out);
    end
    tick();
  endtask

  task automatic test_single_burst();
    logic hs;
    logic own;
    rif.req0 = 1'b1; rif.addr0 = 12'h010; rif.len0 = 4'd3; rif.rready0 = 1'b1;
    @(negedge clk);
    checks++;
    if ({rif.gnt0, rif.gnt1, rif.ROM_read_o, rif.ROM_en_o} !== 4'b1011 ||
        rif.ROM_addr_o !== 12'h010) begin
      errors++;
      $display("FAIL single_grant: gnt0/gnt1/rd/en=%b addr=%h, want 1011 addr=010",
               {rif.gnt0, rif.gnt1, rif.ROM_read_o, rif.ROM_en_o}, rif.ROM_addr_o);
    end
    push_burst(1'b0, 12'h010, 3);
    tick();
    rif.req0 = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      own = exp_q[0].port;
      hs  = own ? (rif.rvalid1 & rif.rready1) : (rif.rvalid0 & rif.rready0);
      checks++;
      if ({rif.rvalid1, rif.rvalid0} !== (own ? 2'b10 : 2'b01) || rif.rdata !== exp_q[0].data ||
          rif.rlast !== exp_q[0].last || rif.ROM_addr_o !== exp_q[0].addr + AW'(hs) ||
          {rif.gnt0, rif.gnt1, rif.ROM_read_o, rif.ROM_en_o} !== 4'b0011) begin
        errors++;
        $display("FAIL single_beat: rv=%b rdata=%h rlast=%b addr=%h g/rd/en=%b, want rdata=%h rlast=%b",
                 {rif.rvalid1, rif.rvalid0}, rif.rdata, rif.rlast, rif.ROM_addr_o,
                 {rif.gnt0, rif.gnt1, rif.ROM_read_o, rif.ROM_en_o}, exp_q[0].data, exp_q[0].last);
      end
      if (hs) void'(exp_q.pop_front());
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_timeout: %0d beats left, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if ({rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
         rif.ROM_en_o} !== 7'b0 || rif.ROM_addr_o !== '0) begin
      errors++;
      $display("FAIL single_idle: gnt/rv/last/rd/en=%b addr=%h, want all 0",
               {rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
                rif.ROM_en_o}, rif.ROM_addr_o);
    end
    tick();
  endtask

  task automatic test_contention();
    logic hs;
    logic own;
    logic p;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rif.addr0 = 12'h100; rif.len0 = 4'd1; rif.addr1 = 12'h200; rif.len1 = 4'd2;
    rif.rready0 = 1'b1; rif.rready1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      p = (k == 1);
      rif.req0 = 1'b1; rif.req1 = 1'b1;
      @(negedge clk);
      checks++;
      if ({rif.gnt1, rif.gnt0} !== (p ? 2'b10 : 2'b01) ||
          rif.ROM_addr_o !== (p ? 12'h200 : 12'h100)) begin
        errors++;
        $display("FAIL contention_grant%0d: gnt1/gnt0=%b addr=%h, want port %0d", k,
                 {rif.gnt1, rif.gnt0}, rif.ROM_addr_o, p);
      end
      push_burst(p, p ? 12'h200 : 12'h100, p ? 2 : 1);
      tick();
      if (p) rif.req1 = 1'b0;
      else   rif.req0 = 1'b0;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
        @(negedge clk);
        own = exp_q[0].port;
        hs  = own ? (rif.rvalid1 & rif.rready1) : (rif.rvalid0 & rif.rready0);
        checks++;
        if ({rif.rvalid1, rif.rvalid0} !== (own ? 2'b10 : 2'b01) ||
            rif.rdata !== exp_q[0].data || rif.rlast !== exp_q[0].last ||
            rif.ROM_addr_o !== exp_q[0].addr + AW'(hs) ||
            {rif.gnt0, rif.gnt1, rif.ROM_read_o, rif.ROM_en_o} !== 4'b0011) begin
          errors++;
          $display("FAIL contention_beat: rv=%b rdata=%h rlast=%b addr=%h g/rd/en=%b, want rdata=%h",
                   {rif.rvalid1, rif.rvalid0}, rif.rdata, rif.rlast, rif.ROM_addr_o,
                   {rif.gnt0, rif.gnt1, rif.ROM_read_o, rif.ROM_en_o}, exp_q[0].data);
        end
        if (hs) void'(exp_q.pop_front());
        tick();
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL contention_timeout: %0d beats left, want 0", exp_q.size());
        exp_q.delete();
      end
    end
    rif.req0 = 1'b0; rif.req1 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic hs;
    logic own;
    int   n_hs;
    n_hs = 0;
    rif.req0 = 1'b1; rif.addr0 = 12'h040; rif.len0 = 4'd1; rif.rready0 = 1'b1;
    @(negedge clk);
    checks++;
    if (rif.gnt0 !== 1'b1 || rif.ROM_addr_o !== 12'h040) begin
      errors++;
      $display("FAIL bp_grant: gnt0=%b addr=%h, want 1 addr=040", rif.gnt0, rif.ROM_addr_o);
    end
    push_burst(1'b0, 12'h040, 1);
    tick();
    rif.req0 = 1'b0;
    rif.rready0 = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      own = exp_q[0].port;
      hs  = own ? (rif.rvalid1 & rif.rready1) : (rif.rvalid0 & rif.rready0);
      checks++;
      if ({rif.rvalid1, rif.rvalid0} !== 2'b01 || rif.rdata !== exp_q[0].data ||
          rif.rlast !== exp_q[0].last || rif.ROM_addr_o !== exp_q[0].addr + AW'(hs) ||
          {rif.gnt0, rif.gnt1, rif.ROM_read_o, rif.ROM_en_o} !== 4'b0011) begin
        errors++;
        $display("FAIL bp_beat: rv=%b rdata=%h rlast=%b addr=%h, want rdata=%h rlast=%b addr=%h",
                 {rif.rvalid1, rif.rvalid0}, rif.rdata, rif.rlast, rif.ROM_addr_o,
                 exp_q[0].data, exp_q[0].last, exp_q[0].addr + AW'(hs));
      end
      if (hs) begin
        n_hs++;
        void'(exp_q.pop_front());
      end
      tick();
      if (c == 1) rif.rready0 = 1'b1;
    end
    checks++;
    if (exp_q.size() != 0 || n_hs != 2) begin
      errors++;
      $display("FAIL bp_count: handshakes=%0d left=%0d, want 2 and 0", n_hs, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_wrap();
    logic hs;
    logic own;
    rif.req1 = 1'b1; rif.addr1 = 12'hFFE; rif.len1 = 4'd2; rif.rready1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({rif.gnt1, rif.gnt0} !== 2'b10 || rif.ROM_addr_o !== 12'hFFE) begin
      errors++;
      $display("FAIL wrap_grant: gnt1/gnt0=%b addr=%h, want 10 addr=ffe",
               {rif.gnt1, rif.gnt0}, rif.ROM_addr_o);
    end
    push_burst(1'b1, 12'hFFE, 2);
    tick();
    rif.req1 = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      own = exp_q[0].port;
      hs  = own ? (rif.rvalid1 & rif.rready1) : (rif.rvalid0 & rif.rready0);
      checks++;
      if ({rif.rvalid1, rif.rvalid0} !== 2'b10 || rif.rdata !== exp_q[0].data ||
          rif.rlast !== exp_q[0].last || rif.ROM_addr_o !== exp_q[0].addr + AW'(hs)) begin
        errors++;
        $display("FAIL wrap_beat: rv=%b rdata=%h rlast=%b addr=%h, want rdata=%h rlast=%b addr=%h",
                 {rif.rvalid1, rif.rvalid0}, rif.rdata, rif.rlast, rif.ROM_addr_o,
                 exp_q[0].data, exp_q[0].last, exp_q[0].addr + AW'(hs));
      end
      if (hs) void'(exp_q.pop_front());
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_timeout: %0d beats left, want 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic hs;
    logic own;
    rif.req0 = 1'b1; rif.addr0 = 12'h300; rif.len0 = 4'd7; rif.rready0 = 1'b1;
    @(negedge clk);
    push_burst(1'b0, 12'h300, 7);
    tick();
    rif.req0 = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 6; c++) begin
      @(negedge clk);
      own = exp_q[0].port;
      hs  = own ? (rif.rvalid1 & rif.rready1) : (rif.rvalid0 & rif.rready0);
      checks++;
      if (rif.rvalid0 !== 1'b1 || rif.rdata !== exp_q[0].data || rif.rlast !== 1'b0) begin
        errors++;
        $display("FAIL abort_beat: rvalid0=%b rdata=%h rlast=%b, want 1 rdata=%h 0",
                 rif.rvalid0, rif.rdata, rif.rlast, exp_q[0].data);
      end
      if (hs) void'(exp_q.pop_front());
      tick();
    end
    exp_q.delete();
    rst = 1'b0;
    #1;
    checks++;
    if ({rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
         rif.ROM_en_o} !== 7'b0 || rif.ROM_addr_o !== '0 || rif.rdata !== rom_out) begin
      errors++;
      $display("FAIL abort_reset: gnt/rv/last/rd/en=%b addr=%h, want all 0",
               {rif.gnt0, rif.gnt1, rif.rvalid0, rif.rvalid1, rif.rlast, rif.ROM_read_o,
                rif.ROM_en_o}, rif.ROM_addr_o);
    end
    tick();
    tick();
    rst = 1'b1;
    rif.req1 = 1'b1; rif.addr1 = 12'h0A0; rif.len1 = 4'd1; rif.rready1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({rif.gnt1, rif.gnt0, rif.rvalid0} !== 3'b100 || rif.ROM_addr_o !== 12'h0A0) begin
      errors++;
      $display("FAIL abort_regrant: gnt1/gnt0/rvalid0=%b addr=%h, want 100 addr=0a0",
               {rif.gnt1, rif.gnt0, rif.rvalid0}, rif.ROM_addr_o);
    end
    push_burst(1'b1, 12'h0A0, 1);
    tick();
    rif.req1 = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      own = exp_q[0].port;
      hs  = own ? (rif.rvalid1 & rif.rready1) : (rif.rvalid0 & rif.rready0);
      checks++;
      if ({rif.rvalid1, rif.rvalid0} !== 2'b10 || rif.rdata !== exp_q[0].data ||
          rif.rlast !== exp_q[0].last || rif.ROM_addr_o !== exp_q[0].addr + AW'(hs)) begin
        errors++;
        $display("FAIL post_reset_beat: rv=%b rdata=%h rlast=%b addr=%h, want rv=10 rdata=%h",
                 {rif.rvalid1, rif.rvalid0}, rif.rdata, rif.rlast, rif.ROM_addr_o,
                 exp_q[0].data);
      end
      if (hs) void'(exp_q.pop_front());
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_timeout: %0d beats left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
